// File: rtl/mestre_projeto.sv
// mestre_projeto: job controller for the polynomial unit (projeto).
//
// It accepts one job at a time over a valid/ready request handshake and
// registers the operands onto X/A/B/C. It then gives a single-cycle start
// pulse on inicio and waits for pronto. The result, or an all-ones abort
// word with erro=1 when pronto does not arrive in time, is offered over a
// valid/ready result handshake. contador counts every delivered job,
// including aborted ones, and wraps at 8 bits.
//
// Parameters
//   TIMEOUT  maximum ESPERA cycles before abort (2..255)
//   W        operand / result width
//
// Ports
//   ck                  clock, rising edge
//   rst                 asynchronous reset, active low
//   req_valid/req_ready job request handshake
//   req_X/A/B/C         job operands
//   inicio              start pulse to the polynomial unit
//   X/A/B/C             operands held for the polynomial unit
//   pronto, Resultado   completion and result from the polynomial unit
//   res_valid/res_ready result handshake
//   res_data, erro      delivered result, timeout flag
//   contador            delivered job count
module mestre_projeto #(
    parameter int TIMEOUT = 255,
    parameter int W       = 16
) (
    input  logic         ck,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_X,
    input  logic [W-1:0] req_A,
    input  logic [W-1:0] req_B,
    input  logic [W-1:0] req_C,
    output logic         inicio,
    output logic [W-1:0] X,
    output logic [W-1:0] A,
    output logic [W-1:0] B,
    output logic [W-1:0] C,
    input  logic         pronto,
    input  logic [W-1:0] Resultado,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         erro,
    output logic [7:0]   contador
);

    typedef enum logic [1:0] {
        OCIOSO,
        DISPARA,
        ESPERA,
        ENTREGA
    } estado_t;

    // Last wait-counter value still allowed in ESPERA; reaching it with
    // pronto low ends the job as a timeout.
    localparam logic [7:0] LIMITE = 8'(TIMEOUT - 1);

    estado_t    estado;
    estado_t    proximo;
    logic [7:0] espera_cnt;

    logic aceita;
    logic conclui;
    logic expira;
    logic entrega;

    assign aceita  = (estado == OCIOSO) && req_valid;
    assign conclui = (estado == ESPERA) && pronto;
    // pronto has priority over an expiring counter in the same cycle.
    assign expira  = (estado == ESPERA) && !pronto && (espera_cnt == LIMITE);
    assign entrega = (estado == ENTREGA) && res_ready;

    // Handshake and strobe outputs decode the state directly, so the
    // asynchronous reset clears them at once.
    assign req_ready = (estado == OCIOSO);
    assign inicio    = (estado == DISPARA);
    assign res_valid = (estado == ENTREGA);

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            estado <= OCIOSO;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo = estado;
        case (estado)
            OCIOSO:  if (req_valid) proximo = DISPARA;
            DISPARA: proximo = ESPERA;
            ESPERA:  if (pronto || expira) proximo = ENTREGA;
            ENTREGA: if (res_ready) proximo = OCIOSO;
            default: proximo = OCIOSO;
        endcase
    end

    // Wait counter: cleared while the start pulse is out, so every job
    // enters ESPERA counting from zero.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            espera_cnt <= '0;
        end else if (estado == DISPARA) begin
            espera_cnt <= '0;
        end else if ((estado == ESPERA) && !pronto) begin
            espera_cnt <= espera_cnt + 8'd1;
        end
    end

    // Operands are only written on acceptance, so they stay stable for the
    // whole job and until the next one is taken.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            X <= '0;
            A <= '0;
            B <= '0;
            C <= '0;
        end else if (aceita) begin
            X <= req_X;
            A <= req_A;
            B <= req_B;
            C <= req_C;
        end
    end

    // Result capture: written once when ESPERA ends, held through ENTREGA.
    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            res_data <= '0;
            erro     <= 1'b0;
        end else if (conclui) begin
            res_data <= Resultado;
            erro     <= 1'b0;
        end else if (expira) begin
            res_data <= '1;
            erro     <= 1'b1;
        end
    end

    always_ff @(posedge ck or negedge rst) begin
        if (!rst) begin
            contador <= '0;
        end else if (entrega) begin
            contador <= contador + 8'd1;
        end
    end

endmodule

// File: tb/tb_mestre_projeto.sv
module tb_mestre_projeto;

    localparam int W  = 16;
    localparam int TO = 8;

    logic         ck;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_X, req_A, req_B, req_C;
    logic         inicio;
    logic [W-1:0] X, A, B, C;
    logic         pronto;
    logic [W-1:0] Resultado;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         erro;
    logic [7:0]   contador;

    mestre_projeto #(.TIMEOUT(TO), .W(W)) dut (
        .ck        (ck),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_X     (req_X),
        .req_A     (req_A),
        .req_B     (req_B),
        .req_C     (req_C),
        .inicio    (inicio),
        .X         (X),
        .A         (A),
        .B         (B),
        .C         (C),
        .pronto    (pronto),
        .Resultado (Resultado),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .erro      (erro),
        .contador  (contador)
    );

    initial begin
        ck = 1'b0;
        forever #5 ck = ~ck;
    end

    // delay: edges after the inicio cycle before the responder raises
    // pronto (0 = never). lat: edges from the end of inicio to res_valid.
    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        logic [W-1:0] exp_data;
        logic         exp_erro;
        int           delay;
        int           lat;
    } job_t;

    typedef struct {
        logic [W-1:0] data;
        logic         erro;
    } exp_t;

    job_t tabela [8];
    exp_t sb [$];

    int tests = 0;
    int fails = 0;

    logic [7:0] cnt_model = 8'd0;
    bit         inc_pending = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] poly(input logic [W-1:0] x, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [W-1:0] c);
        logic [W-1:0] r;
        r = a * x * x + b * x + c;
        return r;
    endfunction

    // Result scoreboard and delivery counter model, sampled on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge ck);
            if (!rst) begin
                cnt_model   = 8'd0;
                inc_pending = 1'b0;
            end else begin
                if (inc_pending) cnt_model = cnt_model + 8'd1;
                inc_pending = 1'b0;
                check("contador", contador, cnt_model);
                if (res_valid && res_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_delivery", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("res_data", res_data, e.data);
                        check("erro", erro, e.erro);
                    end
                    inc_pending = 1'b1;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic run_job(input job_t j, input int hold, input bit spurious);
        int n;
        int lat;
        logic [W-1:0] d0;
        res_ready = (hold == 0);
        if (spurious) begin
            pronto    = 1'b1;
            Resultado = 16'hDEAD;
            repeat (2) @(posedge ck);
            #1;
            check("spurious_idle_res_valid", res_valid, 0);
        end
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge ck); #1;
            n++;
        end
        check("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_X = j.x; req_A = j.a; req_B = j.b; req_C = j.c;
        sb.push_back('{j.exp_data, j.exp_erro});
        @(posedge ck); #1;
        req_valid = 1'b0;
        req_X = 16'($urandom); req_A = 16'($urandom);
        req_B = 16'($urandom); req_C = 16'($urandom);
        check("inicio_on", inicio, 1);
        check("req_ready_busy", req_ready, 0);
        check("operand_X", X, j.x);
        check("operand_C", C, j.c);
        fork
            begin
                if (j.delay != 0) begin
                    repeat (j.delay) @(posedge ck);
                    #1;
                    pronto    = 1'b1;
                    Resultado = poly(X, A, B, C);
                    @(posedge ck); #1;
                    pronto    = 1'b0;
                end
            end
            begin
                @(posedge ck); #1;
                if (spurious) pronto = 1'b0;
                check("inicio_off", inicio, 0);
                lat = 0;
                while (!res_valid && lat < 300) begin
                    @(posedge ck); #1;
                    lat++;
                end
                check("latency", lat, j.lat);
                check("operand_A_held", A, j.a);
                check("operand_B_held", B, j.b);
                if (hold > 0) begin
                    d0 = res_data;
                    repeat (hold) begin
                        @(posedge ck); #1;
                        check("bp_res_valid", res_valid, 1);
                        check("bp_res_data", res_data, d0);
                        check("bp_req_ready", req_ready, 0);
                    end
                    res_ready = 1'b1;
                end
                @(posedge ck); #1;
                check("req_ready_after_delivery", req_ready, 1);
                check("res_valid_after_delivery", res_valid, 0);
            end
        join
    endtask

    initial begin
        job_t jb;
        tabela[0] = '{16'd2,     16'd3, 16'd4,     16'd5,      16'h0019, 1'b0, 3, 3};
        tabela[1] = '{16'd0,     16'd7, 16'd9,     16'h1234,   16'h1234, 1'b0, 1, 1};
        tabela[2] = '{16'd1,     16'd1, 16'd1,     16'd1,      16'h0003, 1'b0, 5, 5};
        tabela[3] = '{16'h0100,  16'd1, 16'd0,     16'd0,      16'h0000, 1'b0, 2, 2};
        tabela[4] = '{16'd3,     16'd3, 16'd3,     16'd3,      16'hFFFF, 1'b1, 0, 8};
        tabela[5] = '{16'd10,    16'd2, 16'd3,     16'd4,      16'h00EA, 1'b0, 7, 7};
        tabela[6] = '{16'd5,     16'd0, 16'h0100,  16'hFFFF,   16'h04FF, 1'b0, 8, 8};
        tabela[7] = '{16'd6,     16'd6, 16'd6,     16'd6,      16'hFFFF, 1'b1, 9, 8};

        rst = 1'b1; req_valid = 1'b0; pronto = 1'b0; res_ready = 1'b1;
        req_X = '0; req_A = '0; req_B = '0; req_C = '0; Resultado = '0;
        #2 rst = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_inicio", inicio, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_erro", erro, 0);
        check("rst_contador", contador, 0);
        check("rst_res_data", res_data, 0);
        check("rst_X", X, 0);
        repeat (2) @(posedge ck);
        #3 rst = 1'b1;

        // Reset in the middle of ESPERA abandons the job.
        @(posedge ck); #1;
        req_valid = 1'b1;
        req_X = 16'd2; req_A = 16'd3; req_B = 16'd4; req_C = 16'd5;
        @(posedge ck); #1;
        req_valid = 1'b0;
        check("midrst_inicio_on", inicio, 1);
        repeat (3) @(posedge ck);
        #4 rst = 1'b0;
        #1;
        check("midrst_inicio", inicio, 0);
        check("midrst_res_valid", res_valid, 0);
        check("midrst_req_ready", req_ready, 1);
        check("midrst_contador", contador, 0);
        check("midrst_X", X, 0);
        check("midrst_res_data", res_data, 0);
        sb.delete();
        repeat (2) @(posedge ck);
        #3 rst = 1'b1;
        @(posedge ck); #1;

        for (int i = 0; i < 8; i++) run_job(tabela[i], 0, 1'b0);

        // Backpressure for five cycles.
        run_job(tabela[0], 5, 1'b0);

        // Spurious pronto while idle and during the start pulse.
        jb = '{16'd1, 16'd1, 16'd1, 16'd1, 16'h0003, 1'b0, 3, 3};
        run_job(jb, 0, 1'b1);

        // 256 back-to-back jobs wrap contador.
        for (int i = 0; i < 256; i++) begin
            jb = '{16'(i), 16'd1, 16'd0, 16'd0, 16'((i * i) & 16'hFFFF), 1'b0, 1, 1};
            run_job(jb, 0, 1'b0);
        end

        repeat (3) @(posedge ck);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        check("contador_final", contador, 8'd10);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
